sample_voice_scheduler: RTL and testbench
=========================================

SAMPLE_VOICE_SCHEDULER -- requirements
Module: sample_voice_scheduler

Interface
REQ-001 Parameter NUM_VOICES, default 4: number of simultaneous playback voices.
REQ-002 Parameter OFS_W, default 12: width of per-voice sample offset.
REQ-003 Parameter SAMPLE_LEN, default 4000: samples per key sample, range 2..2^OFS_W.
REQ-004 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port resetn, input, 1: asynchronous, active-low reset.
REQ-006 Port key_hold, input, 16: level key states from keyboard tracker; bit 0 = q through bit 15 = h (key index k = bit position).
REQ-007 Port sample_tick, input, 1: one-cycle sample-rate strobe.
REQ-008 Port rom_addr, output, 4+OFS_W: {key index, offset} to shared sample ROM.
REQ-009 Port rom_data, input, 8: signed ROM sample, valid exactly 1 cycle after rom_addr.
REQ-010 Port mix_out, output, 10: signed sum of all active voice samples.
REQ-011 Port mix_valid, output, 1: one-cycle strobe marking new mix_out.
REQ-012 Port voice_active, output, NUM_VOICES: bit v high while voice v is playing.
REQ-013 Port overrun, output, 1: sticky flag, sample_tick arrived while busy.

Function
REQ-014 Press = key_hold bit 0->1 versus its registered previous value; each press SHALL set that key's bit in a 16-bit pending register.
REQ-015 In state IDLE only, the lowest-index pending key SHALL be serviced per cycle and its pending bit cleared; presses during mix cycles stay pending.
REQ-016 Service: key already owned by an active voice -> that voice offset reset to 0 (retrigger, no new voice).
REQ-017 Else lowest-index inactive voice SHALL be assigned the key, offset 0, active 1.
REQ-018 Else (all active) voice at steal pointer SHALL be reassigned, offset 0; steal pointer increments modulo NUM_VOICES.
REQ-019 FSM states IDLE, ISSUE, CAPTURE, DONE; IDLE->ISSUE on sample_tick; ISSUE(v)->CAPTURE(v); CAPTURE(v)->ISSUE(v+1), or DONE when v = NUM_VOICES-1; DONE->IDLE.
REQ-020 ISSUE(v) SHALL drive rom_addr = {key of v, offset of v}; inactive voices drive key 0, offset 0.
REQ-021 CAPTURE(v) SHALL add sign-extended rom_data to a 10-bit accumulator if v active, else add 0; accumulator cleared on IDLE->ISSUE.
REQ-022 In CAPTURE(v) for active v: offset = SAMPLE_LEN-1 -> voice goes inactive; otherwise offset increments.
REQ-023 DONE SHALL register accumulator to mix_out and pulse mix_valid; sample_tick to mix_valid latency = 2*NUM_VOICES+1 cycles (9 at default).
REQ-024 mix_out holds its value until the next DONE.
REQ-025 sample_tick outside IDLE SHALL be ignored and set overrun; overrun clears only on reset.
REQ-026 Press and voice end-of-sample in same cycle: end-of-sample applies first; freed voice is eligible next IDLE cycle.

Reset
REQ-027 resetn low SHALL asynchronously clear: FSM to IDLE, all voices inactive, offsets/keys 0, pending 0, previous key_hold 0, steal pointer 0, mix_out 0, mix_valid 0, overrun 0, rom_addr 0.
REQ-028 Reset mid-mix SHALL abandon the mix with no mix_valid pulse; first tick after release starts a fresh mix.

Configuration
REQ-029 Macro SAMPLER_HOLD_GATE_EN defined: key_hold 1->0 for a key owned by an active voice SHALL make that voice inactive at the next IDLE cycle.
REQ-030 Macro undefined: release ignored; voices play to SAMPLE_LEN-1 (one-shot).

Structure
REQ-031 Package sampler_pkg SHALL hold key index constants KEY_Q..KEY_H (0..15), the FSM state enum, and the 10-bit mix width constant.
REQ-032 Sub-module voice_alloc SHALL contain the pending-key priority encoder, owner lookup, free-voice finder and steal pointer.

Verification
REQ-033 Press q (bit 0), 3 ticks, rom_data=8'sd10 -> voice 0 active, rom_addr offsets 0,1,2, mix_out=10 each, mix_valid 9 cycles after each tick.
REQ-034 Press q,w,e,r,t same cycle, all voices free -> voices 0-3 get keys 0-3, t pending then steals voice 0 (steal ptr ->1).
REQ-035 4 active voices, rom_data=-128 -> mix_out=-512 (10'h200), no wrap.
REQ-036 SAMPLE_LEN=4, one voice, 5 ticks -> offsets 0..3, voice_active low after 4th tick, 5th mix_out=0.
REQ-037 sample_tick at cycle 3 of a mix -> ignored, overrun=1; resetn low in ISSUE(2) -> all outputs 0 immediately, no mix_valid.
REQ-038 With SAMPLER_HOLD_GATE_EN, hold then release q -> voice 0 inactive before next tick; without macro -> still active.

Source files
------------

// File: rtl/sampler_pkg.sv
// rtl/sampler_pkg.sv - shared key indices, scheduler state encoding and mix width
package sampler_pkg;

    localparam logic [3:0] KEY_Q = 4'd0;
    localparam logic [3:0] KEY_W = 4'd1;
    localparam logic [3:0] KEY_E = 4'd2;
    localparam logic [3:0] KEY_R = 4'd3;
    localparam logic [3:0] KEY_T = 4'd4;
    localparam logic [3:0] KEY_Y = 4'd5;
    localparam logic [3:0] KEY_U = 4'd6;
    localparam logic [3:0] KEY_I = 4'd7;
    localparam logic [3:0] KEY_O = 4'd8;
    localparam logic [3:0] KEY_P = 4'd9;
    localparam logic [3:0] KEY_A = 4'd10;
    localparam logic [3:0] KEY_S = 4'd11;
    localparam logic [3:0] KEY_D = 4'd12;
    localparam logic [3:0] KEY_F = 4'd13;
    localparam logic [3:0] KEY_G = 4'd14;
    localparam logic [3:0] KEY_H = 4'd15;

    localparam int MIX_W = 10;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

endpackage

// File: rtl/sample_voice_scheduler_if.sv
// rtl/sample_voice_scheduler_if.sv - sample ROM port and mix output bundle
interface sample_voice_scheduler_if #(
    parameter int OFS_W = 12
);
    logic [3+OFS_W:0]               rom_addr;
    logic [7:0]                     rom_data;
    logic [sampler_pkg::MIX_W-1:0]  mix_out;
    logic                           mix_valid;

    modport master (output rom_addr, mix_out, mix_valid, input rom_data);
    modport slave  (input rom_addr, mix_out, mix_valid, output rom_data);
endinterface

// File: rtl/voice_alloc.sv
// rtl/voice_alloc.sv - picks the next pending key and the voice that should play it
module voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int VW         = 2
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic [15:0]                 pending,
    input  logic [NUM_VOICES-1:0]       active,
    input  logic [NUM_VOICES-1:0][3:0]  keys,
    input  logic                        svc_en,
    output logic                        svc_valid,
    output logic [3:0]                  svc_key,
    output logic [VW-1:0]               svc_voice
);
    logic [VW-1:0] steal_ptr;
    logic [VW-1:0] owner_idx, free_idx;
    logic          owner_hit, free_hit;

    // Descending loops leave the lowest matching index as the winner.
    always_comb begin
        svc_valid = |pending;
        svc_key   = 4'd0;
        for (int k = 15; k >= 0; k--)
            if (pending[k]) svc_key = 4'(k);
        owner_hit = 1'b0;
        owner_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (active[v] && keys[v] == svc_key) begin
                owner_hit = 1'b1;
                owner_idx = VW'(v);
            end
            if (!active[v]) begin
                free_hit = 1'b1;
                free_idx = VW'(v);
            end
        end
        if (owner_hit)     svc_voice = owner_idx;
        else if (free_hit) svc_voice = free_idx;
        else               svc_voice = steal_ptr;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            steal_ptr <= '0;
        else if (svc_en && svc_valid && !owner_hit && !free_hit)
            steal_ptr <= (steal_ptr == VW'(NUM_VOICES - 1)) ? '0 : steal_ptr + VW'(1);
    end
endmodule

// File: rtl/sample_voice_scheduler.sv
// rtl/sample_voice_scheduler.sv - voice scheduler and ROM mix sequencer; SAMPLER_HOLD_GATE_EN enables key-release gating
module sample_voice_scheduler
    import sampler_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int OFS_W      = 12,
    parameter int SAMPLE_LEN = 4000
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [15:0]              key_hold,
    input  logic                     sample_tick,
    sample_voice_scheduler_if.master bus,
    output logic [NUM_VOICES-1:0]    voice_active,
    output logic                     overrun
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(SAMPLE_LEN - 1);

    state_t                           state;
    logic [VW-1:0]                    cur, nxt_idx, svc_voice;
    logic [MIX_W-1:0]                 acc, acc_sum;
    logic [NUM_VOICES-1:0]            act, act_n;
    logic [NUM_VOICES-1:0][3:0]       keys, key_n;
    logic [NUM_VOICES-1:0][OFS_W-1:0] ofs, ofs_n;
    logic [15:0]                      pending, key_prev, svc_clear;
    logic                             svc_en, svc_valid;
    logic [3:0]                       svc_key;
    logic [3+OFS_W:0]                 issue_addr;

    voice_alloc #(.NUM_VOICES(NUM_VOICES), .VW(VW)) u_alloc (
        .clock     (clock),
        .resetn    (resetn),
        .pending   (pending),
        .active    (act),
        .keys      (keys),
        .svc_en    (svc_en),
        .svc_valid (svc_valid),
        .svc_key   (svc_key),
        .svc_voice (svc_voice)
    );

`ifdef SAMPLER_HOLD_GATE_EN
    logic [15:0] rel_pend;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) rel_pend <= '0;
        else         rel_pend <= ((state == IDLE) ? 16'd0 : rel_pend) | (key_prev & ~key_hold);
    end
`endif

    assign svc_en    = (state == IDLE);
    assign svc_clear = (svc_en && svc_valid) ? (16'd1 << svc_key) : 16'd0;

    // Servicing (IDLE) and end-of-sample (CAPTURE) live in different states, so they never collide.
    always_comb begin
        act_n = act;
        key_n = keys;
        ofs_n = ofs;
`ifdef SAMPLER_HOLD_GATE_EN
        if (state == IDLE)
            for (int v = 0; v < NUM_VOICES; v++)
                if (rel_pend[keys[v]]) act_n[v] = 1'b0;
`endif
        if (svc_en && svc_valid) begin
            act_n[svc_voice] = 1'b1;
            key_n[svc_voice] = svc_key;
            ofs_n[svc_voice] = '0;
        end
        if (state == CAPTURE && act[cur]) begin
            if (ofs[cur] == LAST_OFS) act_n[cur] = 1'b0;
            else                      ofs_n[cur] = ofs[cur] + OFS_W'(1);
        end
    end

    // Address is registered on entry to ISSUE, so it is built from next-state voice values.
    assign nxt_idx    = (state == IDLE) ? '0 : cur + VW'(1);
    assign issue_addr = act_n[nxt_idx] ? {key_n[nxt_idx], ofs_n[nxt_idx]} : '0;
    assign acc_sum    = acc + (act[cur] ? {{(MIX_W-8){bus.rom_data[7]}}, bus.rom_data} : '0);
    assign voice_active = act;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cur           <= '0;
            acc           <= '0;
            act           <= '0;
            keys          <= '0;
            ofs           <= '0;
            pending       <= '0;
            key_prev      <= '0;
            overrun       <= 1'b0;
            bus.rom_addr  <= '0;
            bus.mix_out   <= '0;
            bus.mix_valid <= 1'b0;
        end else begin
            act           <= act_n;
            keys          <= key_n;
            ofs           <= ofs_n;
            key_prev      <= key_hold;
            pending       <= (pending & ~svc_clear) | (key_hold & ~key_prev);
            bus.mix_valid <= 1'b0;
            if (sample_tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (sample_tick) begin
                    state        <= ISSUE;
                    cur          <= '0;
                    acc          <= '0;
                    bus.rom_addr <= issue_addr;
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    acc <= acc_sum;
                    if (cur == VW'(NUM_VOICES - 1)) begin
                        state         <= DONE;
                        bus.mix_out   <= acc_sum;
                        bus.mix_valid <= 1'b1;
                    end else begin
                        state        <= ISSUE;
                        cur          <= nxt_idx;
                        bus.rom_addr <= issue_addr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_voice_scheduler.sv
// tb/tb_sample_voice_scheduler.sv - scoreboard bench for sample_voice_scheduler
`timescale 1ns/1ps
module tb_sample_voice_scheduler;
    import sampler_pkg::*;

    localparam int NV = 4;
    localparam int OW = 12;
    localparam int SL = 4;
    localparam logic [15:0] Z = 16'd0;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          sample_tick = 1'b0;
    logic [15:0]   key_hold = 16'd0;
    logic [NV-1:0] voice_active;
    logic          overrun;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    logic [7:0]    rom_val [16];

    typedef struct {
        int          due;
        logic [31:0] val;
        string       name;
    } exp_t;
    exp_t mq[$];
    exp_t aq[$];

    sample_voice_scheduler_if #(.OFS_W(OW)) bus();

    sample_voice_scheduler #(.NUM_VOICES(NV), .OFS_W(OW), .SAMPLE_LEN(SL)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .key_hold     (key_hold),
        .sample_tick  (sample_tick),
        .bus          (bus),
        .voice_active (voice_active),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    // ROM model: data for the key field of the address, one cycle later.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        bus.rom_data <= rom_val[bus.rom_addr[OW+3:OW]];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [15:0] ad(input logic [3:0] k, input int o);
        return {k, 12'(o)};
    endfunction

    always @(negedge clock) begin
        if (aq.size() != 0 && aq[0].due == cyc) begin
            check(aq[0].name, 32'(bus.rom_addr), aq[0].val);
            void'(aq.pop_front());
        end
        if (bus.mix_valid) begin
            if (mq.size() == 0) check("mix_valid_unexpected", 32'(bus.mix_valid), 32'd0);
            else begin
                check({mq[0].name, "_latency"}, 32'(cyc), 32'(mq[0].due));
                check(mq[0].name, 32'(bus.mix_out), mq[0].val);
                void'(mq.pop_front());
            end
        end else if (mq.size() != 0 && mq[0].due < cyc) begin
            check({mq[0].name, "_timeout"}, 32'(bus.mix_valid), 32'd1);
            void'(mq.pop_front());
        end
    end

    task automatic do_tick(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                           input logic [15:0] a3, input logic [9:0] mix, input string tag,
                           input logic extra);
        logic [15:0] a [4];
        exp_t e;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        sample_tick = 1'b1;
        for (int v = 0; v < 4; v++) begin
            e.due  = cyc + 1 + 2 * v;
            e.val  = 32'(a[v]);
            e.name = $sformatf("%s_addr_v%0d", tag, v);
            aq.push_back(e);
        end
        e.due  = cyc + 9;
        e.val  = 32'(mix);
        e.name = {tag, "_mix"};
        mq.push_back(e);
        @(negedge clock); sample_tick = 1'b0;
        @(negedge clock); sample_tick = extra;
        @(negedge clock); sample_tick = 1'b0;
        repeat (9) @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 16; k++) rom_val[k] = 8'd10;
        repeat (3) @(negedge clock);
        check("rst_voice_active", 32'(voice_active), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_mix_out", 32'(bus.mix_out), 32'd0);
        check("rst_mix_valid", 32'(bus.mix_valid), 32'd0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        key_hold = 16'h0001;
        repeat (3) @(negedge clock);
        check("press_q_active", 32'(voice_active), 32'h1);
        do_tick(ad(KEY_Q, 0), Z, Z, Z, 10'd10, "q_t1", 1'b0);
        do_tick(ad(KEY_Q, 1), Z, Z, Z, 10'd10, "q_t2", 1'b0);
        do_tick(ad(KEY_Q, 2), Z, Z, Z, 10'd10, "q_t3", 1'b0);
        check("q_t3_active", 32'(voice_active), 32'h1);
        do_tick(ad(KEY_Q, 3), Z, Z, Z, 10'd10, "q_t4", 1'b0);
        check("q_end_inactive", 32'(voice_active), 32'h0);
        do_tick(Z, Z, Z, Z, 10'd0, "q_t5", 1'b0);

        key_hold = 16'h0000;
        repeat (2) @(negedge clock);
        rom_val[1] = 8'd20; rom_val[2] = 8'd30; rom_val[3] = 8'd40; rom_val[4] = 8'h9C;
        key_hold = 16'h001F;
        repeat (7) @(negedge clock);
        check("five_keys_active", 32'(voice_active), 32'hF);
        do_tick(ad(KEY_T, 0), ad(KEY_W, 0), ad(KEY_E, 0), ad(KEY_R, 0), 10'h3F6, "steal_a", 1'b0);
        rom_val[5] = 8'd7;
        key_hold = 16'h003F;
        repeat (3) @(negedge clock);
        do_tick(ad(KEY_T, 1), ad(KEY_Y, 0), ad(KEY_E, 1), ad(KEY_R, 1), 10'h3E9, "steal_b", 1'b0);

        for (int k = 0; k < 16; k++) rom_val[k] = 8'h80;
        do_tick(ad(KEY_T, 2), ad(KEY_Y, 1), ad(KEY_E, 2), ad(KEY_R, 2), 10'h200, "full_neg", 1'b0);

        rom_val[4] = 8'd1; rom_val[5] = 8'd2; rom_val[2] = 8'd3; rom_val[3] = 8'd4;
        check("overrun_before", 32'(overrun), 32'd0);
        do_tick(ad(KEY_T, 3), ad(KEY_Y, 2), ad(KEY_E, 3), ad(KEY_R, 3), 10'd10, "overrun_mix", 1'b1);
        check("overrun_set", 32'(overrun), 32'd1);
        check("after_end_active", 32'(voice_active), 32'h2);

        sample_tick = 1'b1;
        @(negedge clock); sample_tick = 1'b0;
        repeat (4) @(negedge clock);
        resetn = 1'b0;
        #1;
        check("midrst_voice_active", 32'(voice_active), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        check("midrst_mix_out", 32'(bus.mix_out), 32'd0);
        check("midrst_mix_valid", 32'(bus.mix_valid), 32'd0);
        check("midrst_rom_addr", 32'(bus.rom_addr), 32'd0);
        key_hold = 16'h0000;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (12) @(negedge clock);
        do_tick(Z, Z, Z, Z, 10'd0, "post_reset", 1'b0);

        rom_val[0] = 8'd5;
        key_hold = 16'h0001;
        repeat (3) @(negedge clock);
        check("hold_press_active", 32'(voice_active), 32'h1);
        key_hold = 16'h0000;
        repeat (3) @(negedge clock);
`ifdef SAMPLER_HOLD_GATE_EN
        check("release_gated", 32'(voice_active), 32'h0);
        do_tick(Z, Z, Z, Z, 10'd0, "release_mix", 1'b0);
`else
        check("release_oneshot", 32'(voice_active), 32'h1);
        do_tick(ad(KEY_Q, 0), Z, Z, Z, 10'd5, "release_mix", 1'b0);
`endif

        repeat (5) @(negedge clock);
        check("queues_drained", 32'(mq.size() + aq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
